// File: rtl/sprite_render.sv
// One 16x16 sprite: position double-buffer, inside test, ROM request stage and
// registered colour stage, plus animation-frame and blink sequencing.
module sprite_render #(
    parameter int unsigned ANIM_DIV = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_hcount,
    input  logic [9:0] i_vcount,
    input  logic       i_video_on,
    input  logic       i_frame_tick,
    input  logic [9:0] i_pos_x,
    input  logic [9:0] i_pos_y,
    input  logic       i_pos_valid,
    output logic       o_pos_ready,
    input  logic [3:0] i_base_index,
    input  logic [1:0] i_frame_last,
    input  logic       i_blink,
    output logic [7:0] o_rom_addr,
    output logic [3:0] o_rom_index,
    output logic       o_rom_en,
    output logic       o_rom_inv,
    input  logic       i_rom_r,
    input  logic       i_rom_g,
    input  logic       i_rom_b,
    output logic       o_r,
    output logic       o_g,
    output logic       o_b,
    output logic       o_de,
    output logic       o_hit
);
    // Handshake: an update transfers when i_pos_valid and o_pos_ready are both
    // high at a clock edge; o_pos_ready is low while an update waits for frame_tick.
    localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

    logic [9:0] r_act_x, r_act_y, r_pend_x, r_pend_y;
    logic       r_pend_full;
    logic [7:0] r_div;
    logic [1:0] r_frame_sel;
    logic       r_phase;
    logic [7:0] r_rom_addr;
    logic [3:0] r_rom_index;
    logic       r_rom_en, r_rom_inv, r_de1;
    logic       r_r, r_g, r_b, r_hit, r_de;

    logic        w_take, w_wrap, w_inside;
    logic [10:0] w_hx, w_vy, w_ax, w_ay;
    logic [3:0]  w_col, w_row;

    assign o_pos_ready = ~r_pend_full;
    assign w_take      = i_pos_valid & ~r_pend_full;
    assign w_wrap      = i_frame_tick & (r_div >= DIV_LAST);

    // 11-bit compare so a sprite near the right/bottom edge clips instead of wrapping
    assign w_hx     = {1'b0, i_hcount};
    assign w_vy     = {1'b0, i_vcount};
    assign w_ax     = {1'b0, r_act_x};
    assign w_ay     = {1'b0, r_act_y};
    assign w_inside = i_video_on &
                      (w_hx >= w_ax) & (w_hx < w_ax + 11'd16) &
                      (w_vy >= w_ay) & (w_vy < w_ay + 11'd16);
    assign w_col    = i_hcount[3:0] - r_act_x[3:0];
    assign w_row    = i_vcount[3:0] - r_act_y[3:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_act_x     <= '0;
            r_act_y     <= '0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pend_full <= 1'b0;
        end else if (w_take && i_frame_tick) begin
            r_act_x <= i_pos_x;
            r_act_y <= i_pos_y;
        end else begin
            if (i_frame_tick && r_pend_full) begin
                r_act_x     <= r_pend_x;
                r_act_y     <= r_pend_y;
                r_pend_full <= 1'b0;
            end
            if (w_take) begin
                r_pend_x    <= i_pos_x;
                r_pend_y    <= i_pos_y;
                r_pend_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div       <= '0;
            r_frame_sel <= '0;
            r_phase     <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_div       <= '0;
                r_frame_sel <= (r_frame_sel >= i_frame_last) ? 2'd0 : r_frame_sel + 2'd1;
            end else if (i_frame_tick) begin
                r_div <= r_div + 8'd1;
            end
            if (!i_blink)
                r_phase <= 1'b0;
            else if (w_wrap)
                r_phase <= ~r_phase;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rom_addr  <= '0;
            r_rom_index <= '0;
            r_rom_en    <= 1'b0;
            r_rom_inv   <= 1'b0;
            r_de1       <= 1'b0;
            r_r         <= 1'b0;
            r_g         <= 1'b0;
            r_b         <= 1'b0;
            r_hit       <= 1'b0;
            r_de        <= 1'b0;
        end else begin
            r_rom_addr  <= w_inside ? {w_row, w_col} : 8'h00;
            r_rom_index <= i_base_index + {2'b00, r_frame_sel};
            r_rom_en    <= w_inside;
            r_rom_inv   <= i_blink & r_phase;
            r_de1       <= i_video_on;
            // ROM colour is combinational from the stage-1 request
            r_r         <= r_rom_en & i_rom_r;
            r_g         <= r_rom_en & i_rom_g;
            r_b         <= r_rom_en & i_rom_b;
            r_hit       <= r_rom_en & (i_rom_r | i_rom_g | i_rom_b);
            r_de        <= r_de1;
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_rom_index = r_rom_index;
    assign o_rom_en    = r_rom_en;
    assign o_rom_inv   = r_rom_inv;
    assign o_r         = r_r;
    assign o_g         = r_g;
    assign o_b         = r_b;
    assign o_hit       = r_hit;
    assign o_de        = r_de;

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render: pixel tables, position handshake,
// animation/blink sequencing, edge clipping and mid-line reset.
module tb_sprite_render;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hcount, vcount, pos_x, pos_y;
    logic       video_on, frame_tick, pos_valid, pos_ready;
    logic [3:0] base_index, rom_index;
    logic [1:0] frame_last;
    logic       blink, rom_en, rom_inv, rom_r, rom_g, rom_b;
    logic [7:0] rom_addr;
    logic       r, g, b, de, hit;
    logic [2:0] tb_pix;

    int n_checks = 0;
    int n_err    = 0;

    // model state for the animation divider
    int m_div, m_sel, m_phase;

    typedef struct {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       vo;
        logic       en;
        logic [7:0] addr;
    } pix_vec_t;

    pix_vec_t tab_a[8];
    pix_vec_t tab_b[7];

    always #5 clk = ~clk;

    // ROM stand-in: fixed pixel colour, inverted by rom_inv, zero when disabled
    assign rom_r = rom_en & (tb_pix[2] ^ rom_inv);
    assign rom_g = rom_en & (tb_pix[1] ^ rom_inv);
    assign rom_b = rom_en & (tb_pix[0] ^ rom_inv);

    sprite_render #(.ANIM_DIV(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_hcount(hcount), .i_vcount(vcount), .i_video_on(video_on),
        .i_frame_tick(frame_tick),
        .i_pos_x(pos_x), .i_pos_y(pos_y), .i_pos_valid(pos_valid), .o_pos_ready(pos_ready),
        .i_base_index(base_index), .i_frame_last(frame_last), .i_blink(blink),
        .o_rom_addr(rom_addr), .o_rom_index(rom_index), .o_rom_en(rom_en), .o_rom_inv(rom_inv),
        .i_rom_r(rom_r), .i_rom_g(rom_g), .i_rom_b(rom_b),
        .o_r(r), .o_g(g), .o_b(b), .o_de(de), .o_hit(hit)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic vo);
        hcount   = 10'(x);
        vcount   = 10'(y);
        video_on = vo;
    endtask

    task automatic pix_en(input string name, input int x, input int y, input int en, input int addr);
        pix(x, y, 1'b1);
        step();
        chk({name, ".en"}, int'(rom_en), en);
        chk({name, ".addr"}, int'(rom_addr), addr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_div = 0; m_sel = 0; m_phase = 0;
    endtask

    // one frame_tick pulse, then one idle clock so rom_* reflect the new state
    task automatic tick_and_check(input string name);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        if (m_div == 1) begin
            m_div = 0;
            m_sel = (m_sel >= int'(frame_last)) ? 0 : m_sel + 1;
            m_phase = blink ? 1 - m_phase : 0;
        end else begin
            m_div++;
        end
        if (!blink) m_phase = 0;
        step();
        chk({name, ".index"}, int'(rom_index), (int'(base_index) + m_sel) % 16);
        chk({name, ".inv"}, int'(rom_inv), blink ? m_phase : 0);
    endtask

    initial begin
        tab_a[0] = '{10'd100, 10'd50, 1'b1, 1'b1, 8'h00};
        tab_a[1] = '{10'd115, 10'd65, 1'b1, 1'b1, 8'hFF};
        tab_a[2] = '{10'd116, 10'd50, 1'b1, 1'b0, 8'h00};
        tab_a[3] = '{10'd99,  10'd50, 1'b1, 1'b0, 8'h00};
        tab_a[4] = '{10'd107, 10'd60, 1'b1, 1'b1, 8'hA7};
        tab_a[5] = '{10'd100, 10'd50, 1'b0, 1'b0, 8'h00};
        tab_a[6] = '{10'd100, 10'd66, 1'b1, 1'b0, 8'h00};
        tab_a[7] = '{10'd115, 10'd50, 1'b1, 1'b1, 8'h0F};

        tab_b[0] = '{10'd630, 10'd470, 1'b1, 1'b1, 8'h00};
        tab_b[1] = '{10'd639, 10'd479, 1'b1, 1'b1, 8'h99};
        tab_b[2] = '{10'd639, 10'd470, 1'b1, 1'b1, 8'h09};
        tab_b[3] = '{10'd629, 10'd470, 1'b1, 1'b0, 8'h00};
        tab_b[4] = '{10'd630, 10'd469, 1'b1, 1'b0, 8'h00};
        tab_b[5] = '{10'd0,   10'd0,   1'b1, 1'b0, 8'h00};
        tab_b[6] = '{10'd5,   10'd475, 1'b1, 1'b0, 8'h00};

        rst_n = 1'b0; pix(0, 0, 1'b0); frame_tick = 1'b0;
        pos_x = '0; pos_y = '0; pos_valid = 1'b0;
        base_index = 4'd0; frame_last = 2'd0; blink = 1'b0; tb_pix = 3'b000;
        step(); step();
        chk("rst.ready", int'(pos_ready), 1);
        chk("rst.en", int'(rom_en), 0);
        chk("rst.index", int'(rom_index), 0);
        chk("rst.rgbhd", int'({r, g, b, hit, de}), 0);
        do_reset();

        // position (100,50) via pending path
        pos_x = 10'd100; pos_y = 10'd50; pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        chk("pos1.ready_low", int'(pos_ready), 0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("pos1.ready_high", int'(pos_ready), 1);

        foreach (tab_a[i]) begin
            pix(int'(tab_a[i].hc), int'(tab_a[i].vc), tab_a[i].vo);
            step();
            chk($sformatf("tabA%0d.en", i), int'(rom_en), int'(tab_a[i].en));
            chk($sformatf("tabA%0d.addr", i), int'(rom_addr), int'(tab_a[i].addr));
        end

        // colour latency: pixel presented once, colour appears two edges later
        tb_pix = 3'b101;
        pix(104, 52, 1'b1);
        step();
        pix(0, 0, 1'b0);
        step();
        chk("lat.rgb", int'({r, g, b}), 5);
        chk("lat.hit", int'(hit), 1);
        chk("lat.de", int'(de), 1);
        step();
        chk("lat.rgb_off", int'({r, g, b}), 0);
        chk("lat.de_off", int'(de), 0);

        // mid-frame offer waits for frame_tick; second offer refused
        pos_x = 10'd200; pos_y = 10'd200; pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        chk("pos2.ready_low", int'(pos_ready), 0);
        pix_en("pos2.old", 100, 50, 1, 8'h00);
        pos_x = 10'd300; pos_y = 10'd300; pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        chk("pos2.refused", int'(pos_ready), 0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("pos2.ready_back", int'(pos_ready), 1);
        pix_en("pos2.new", 200, 200, 1, 8'h00);
        pix_en("pos2.not300", 300, 300, 0, 8'h00);
        pix_en("pos2.not100", 100, 50, 0, 8'h00);

        // capture and frame_tick in the same cycle
        pos_x = 10'd10; pos_y = 10'd10; pos_valid = 1'b1; frame_tick = 1'b1;
        step();
        pos_valid = 1'b0; frame_tick = 1'b0;
        chk("pos3.ready", int'(pos_ready), 1);
        pix_en("pos3.tl", 10, 10, 1, 8'h00);
        pix_en("pos3.br", 25, 25, 1, 8'hFF);

        // animation and blink, ANIM_DIV=2
        base_index = 4'd6; frame_last = 2'd3; blink = 1'b1;
        do_reset();
        step();
        chk("anim.start", int'(rom_index), 6);
        for (int k = 0; k < 8; k++) tick_and_check($sformatf("anim6_%0d", k));
        base_index = 4'd14;
        step();
        chk("anim.base14", int'(rom_index), 14);
        for (int k = 0; k < 8; k++) tick_and_check($sformatf("anim14_%0d", k));
        for (int k = 0; k < 10 && m_sel != 3; k++) tick_and_check($sformatf("seek3_%0d", k));
        chk("anim.at3", m_sel, 3);
        frame_last = 2'd1;
        for (int k = 0; k < 4; k++) tick_and_check($sformatf("lower_%0d", k));

        // black pixel inverted while phase is high
        for (int k = 0; k < 6 && m_phase != 1; k++) tick_and_check($sformatf("seekph_%0d", k));
        chk("blink.phase", int'(rom_inv), 1);
        tb_pix = 3'b000;
        pix(3, 3, 1'b1);
        step(); step();
        chk("blink.rgb", int'({r, g, b}), 7);
        chk("blink.hit", int'(hit), 1);
        blink = 1'b0;
        step();
        chk("blink.off", int'(rom_inv), 0);

        // edge clipping at (630,470)
        pos_x = 10'd630; pos_y = 10'd470; pos_valid = 1'b1; frame_tick = 1'b1;
        step();
        pos_valid = 1'b0; frame_tick = 1'b0;
        m_div = 0;
        foreach (tab_b[i]) begin
            pix(int'(tab_b[i].hc), int'(tab_b[i].vc), tab_b[i].vo);
            step();
            chk($sformatf("tabB%0d.en", i), int'(rom_en), int'(tab_b[i].en));
            chk($sformatf("tabB%0d.addr", i), int'(rom_addr), int'(tab_b[i].addr));
        end

        // mid-line reset with a pending update outstanding
        base_index = 4'd5; tb_pix = 3'b111;
        pos_x = 10'd50; pos_y = 10'd50; pos_valid = 1'b1;
        pix(635, 475, 1'b1);
        step();
        pos_valid = 1'b0;
        step();
        chk("mid.pre_rgb", int'({r, g, b}), 7);
        chk("mid.pre_ready", int'(pos_ready), 0);
        rst_n = 1'b0;
        step();
        chk("mid.rst_en", int'(rom_en), 0);
        chk("mid.rst_addr", int'(rom_addr), 0);
        chk("mid.rst_index", int'(rom_index), 0);
        chk("mid.rst_out", int'({r, g, b, hit, de, rom_inv}), 0);
        chk("mid.rst_ready", int'(pos_ready), 1);
        rst_n = 1'b1;
        frame_tick = 1'b1; pix(0, 0, 1'b0); step(); frame_tick = 1'b0;
        pix_en("mid.at00", 0, 0, 1, 8'h00);
        pix_en("mid.not50", 50, 50, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sprite_render.md
# sprite_render

Pixel-pipeline client of the sprite bitmap ROM: converts the VGA timing generator's current pixel coordinates into ROM address/index/enable/invert requests for one 16x16 sprite and registers the returned colour into the video path. Also owns the sprite's on-screen position, with a frame-synchronous update handshake, plus the animation-frame and blink sequencing. Sits between the VGA timing block / game logic and the sprite ROM. One instance per on-screen sprite; the colour mux combines the `hit` outputs.

## Interface
- `ANIM_DIV`, default 8: frame_tick pulses per animation step, 1..255
- `clk`  in  1  pixel clock
- `rst_n`  in  1  synchronous, active-low reset
- `hcount`  in  10  current pixel column, 0..639
- `vcount`  in  10  current pixel row, 0..479
- `video_on`  in  1  active-video qualifier for hcount/vcount
- `frame_tick`  in  1  one-cycle pulse at start of vertical blank
- `pos_x`  in  10  requested sprite left column
- `pos_y`  in  10  requested sprite top row
- `pos_valid`  in  1  position update offered
- `pos_ready`  out  1  position update can be accepted
- `base_index`  in  4  ROM picture index of animation frame 0
- `frame_last`  in  2  number of animation frames minus 1, 0..3
- `blink`  in  1  enable periodic colour inversion
- `rom_addr`  out  8  {row[3:0], col[3:0]} within sprite
- `rom_index`  out  4  picture select to ROM
- `rom_en`  out  1  ROM output enable
- `rom_inv`  out  1  ROM invert control
- `rom_r`, `rom_g`, `rom_b`  in  1 each  combinational ROM colour
- `r`, `g`, `b`  out  1 each  registered sprite colour
- `de`  out  1  video_on delayed to align with r/g/b
- `hit`  out  1  sprite pixel present (non-black) at r/g/b

## Operation
- Position: a pending register and an active register.
  - `pos_valid & pos_ready` captures pos_x/pos_y into pending; `pos_ready` drops.
  - On `frame_tick` with pending full: active <= pending, `pos_ready` rises next cycle.
  - Capture and frame_tick in the same cycle: captured value goes straight to active; pending stays empty; `pos_ready` stays 1.
  - Active position never changes outside frame_tick, so there is no tearing.
- Inside test: uses 11-bit arithmetic.
  - Inside when `video_on & hcount >= ax & hcount < ax+16 & vcount >= ay & vcount < ay+16`.
  - A sprite partly past 639/479 is clipped, never wrapped.
- Address: `rom_addr = {(vcount-ay)[3:0], (hcount-ax)[3:0]}` when inside, else 0.
- Animation:
  - An 8-bit divider counts frame_ticks 0..ANIM_DIV-1.
  - At wrap, frame_sel advances, and wraps to 0 after reaching `frame_last`.
  - If `frame_last` is lowered below frame_sel, frame_sel goes to 0 at the next step.
  - `rom_index = base_index + frame_sel`, 4-bit modulo.
- Blink:
  - With `blink=1`, a phase bit toggles at each divider wrap; `rom_inv` = phase.
  - With `blink=0`, the phase is cleared and `rom_inv` = 0.
- `rom_en` = registered inside flag.
- Colour: `r/g/b` = registered rom_r/g/b when stage-1 inside is set, else 0. `hit` = stage-1 inside & (rom_r|rom_g|rom_b).

## Timing
- Stage 1 (edge after inputs): rom_addr, rom_index, rom_inv, rom_en registered; the ROM returns colour combinationally in the same cycle.
- Stage 2: r, g, b, hit, de registered.
- Latency: hcount/vcount/video_on to r/g/b/hit/de is 2 clocks. The timing generator delays hsync/vsync by 2 to match.
- Reset (rst_n=0 at an edge) clears:
  - active and pending position to (0,0); pos_ready=1
  - divider, frame_sel and phase to 0
  - rom_addr=0, rom_index=0, rom_en=0, rom_inv=0
  - r=g=b=0, hit=0, de=0
- Reset mid-frame discards any pending update. The sprite reappears at (0,0) from the next valid pixel.
- base_index, frame_last and blink are sampled every cycle; changes show 1 clock later on rom_* outputs.

## Test plan
- Reset, then pos (100,50) offered and accepted, frame_tick: pixel (100,50) gives rom_addr=0x00 and rom_en=1 one clock later; pixel (115,65) gives 0xFF; pixels (116,50) and (99,50) give rom_en=0. r/g/b follow ROM output 2 clocks after hcount.
- Offer (200,200) mid-frame with no frame_tick: pos_ready=0 and the sprite stays at (100,50). A second offer is refused. After frame_tick the sprite is at (200,200) and pos_ready=1.
- pos_valid and frame_tick in the same cycle with (10,10): applied immediately and pos_ready stays 1.
- ANIM_DIV=2, base_index=6, frame_last=3: rom_index sequence 6,7,8,9,6 changes every 2 frame_ticks. base_index=14, frame_last=3 gives 14,15,0,1.
- blink=1, ANIM_DIV=2: rom_inv toggles every 2 frame_ticks. While inside, a black ROM pixel with inv=1 gives r=g=b=1 and hit=1. Setting blink=0 forces rom_inv=0 next clock.
- Sprite at (630,470): only columns 630..639 and rows 470..479 are enabled. Pixel (0,0) is not enabled. Asserting rst_n=0 mid-line gives all outputs 0 at the next edge and pos_ready=1.
